// File: rtl/i2s_tx_if.sv
// Stereo sample stream handshake between the synth core (master) and the I2S transmitter (slave).
interface i2s_tx_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] sample_l;
  logic [DATA_W-1:0] sample_r;
  logic              sample_valid;
  logic              sample_ready;

  modport master (output sample_l, sample_r, sample_valid, input  sample_ready);
  modport slave  (input  sample_l, sample_r, sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: regenerates sclk from the lrck edges and shifts L/R samples MSB-first with a 1-bit delay.
// Optional I2S_TX_UNDERRUN_HOLD_EN: an underrun repeats the last transmitted pair instead of muting.
module i2s_tx #(
  parameter int DATA_W   = 16,
  parameter int SCLK_DIV = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      mclk_in,
  input  logic      lrck_in,
  i2s_tx_if.slave   s_if,
  output logic      mclk,
  output logic      lrck,
  output logic      sclk,
  output logic      sdata,
  output logic      underrun
);
  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic              r_mclk, r_lrck_d, r_sclk, r_sdata, r_underrun, r_full;
  logic [DIV_W-1:0]  r_div;
  logic [CNT_W-1:0]  r_bitcnt;
  logic [DATA_W-1:0] r_buf_l, r_buf_r, r_shift, r_rlatch;
  logic [DATA_W-1:0] w_fill_l, w_fill_r;
  logic              w_edge, w_fall, w_rise, w_accept, w_div_end;

  assign w_edge    = lrck_in ^ r_lrck_d;
  assign w_fall    = w_edge & ~lrck_in;
  assign w_rise    = w_edge &  lrck_in;
  assign w_accept  = s_if.sample_valid & ~r_full;
  assign w_div_end = (r_div == DIV_W'(SCLK_DIV - 1));

  assign s_if.sample_ready = ~r_full;
  assign mclk     = r_mclk;
  assign lrck     = r_lrck_d;
  assign sclk     = r_sclk;
  assign sdata    = r_sdata;
  assign underrun = r_underrun;

`ifdef I2S_TX_UNDERRUN_HOLD_EN
  logic [DATA_W-1:0] r_last_l, r_last_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_l <= '0;
      r_last_r <= '0;
    end else if (w_fall && r_full) begin
      r_last_l <= r_buf_l;
      r_last_r <= r_buf_r;
    end
  end

  assign w_fill_l = r_last_l;
  assign w_fill_r = r_last_r;
`else
  assign w_fill_l = '0;
  assign w_fill_r = '0;
`endif

  // Holding buffer: ready only when empty, so accept and frame-start load never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full  <= 1'b0;
      r_buf_l <= '0;
      r_buf_r <= '0;
    end else if (w_accept) begin
      r_full  <= 1'b1;
      r_buf_l <= s_if.sample_l;
      r_buf_r <= s_if.sample_r;
    end else if (w_fall) begin
      r_full  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mclk     <= 1'b0;
      r_lrck_d   <= 1'b0;
      r_sclk     <= 1'b0;
      r_sdata    <= 1'b0;
      r_underrun <= 1'b0;
      r_div      <= '0;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_rlatch   <= '0;
    end else begin
      r_mclk     <= mclk_in;
      r_lrck_d   <= lrck_in;
      r_underrun <= 1'b0;

      if (w_fall) begin
        if (r_full) begin
          r_shift  <= r_buf_l;
          r_rlatch <= r_buf_r;
        end else begin
          r_shift    <= w_fill_l;
          r_rlatch   <= w_fill_r;
          r_underrun <= 1'b1;
        end
      end else if (w_rise) begin
        r_shift <= r_rlatch;
      end

      // Every lrck edge restarts the bit clock so sclk stays phase-locked to the frame.
      if (w_edge) begin
        r_div    <= '0;
        r_sclk   <= 1'b0;
        r_bitcnt <= '0;
        r_sdata  <= 1'b0;
      end else if (w_div_end) begin
        r_div  <= '0;
        r_sclk <= ~r_sclk;
        if (r_sclk) begin
          if (r_bitcnt < CNT_W'(DATA_W)) begin
            r_sdata  <= r_shift[DATA_W-1];
            r_shift  <= r_shift << 1;
            r_bitcnt <= r_bitcnt + 1'b1;
          end else begin
            r_sdata  <= 1'b0;
          end
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end
endmodule
